pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the multi-cycle CPU; replaces the bare PC register.
//  Computes next PC internally: sequential, branch, jump, register/return.
//  Adds write-enable stall, boot/halt state machine and a DEPTH-entry return-address stack (RAS).
//  Sits between control unit / register file and instruction memory address port.
// PARAMETERS
//  WIDTH        32            PC / address width (>=8)
//  RESET_VECTOR 32'h00000000  PC value loaded on reset
//  RAS_DEPTH    4             return-address stack entries (power of 2, >=2)
//  TRAP_VECTOR  32'h00000080  redirect target for misaligned targets (PC_TRAP_EN only)
// PORTS
//  click         in  1      clock, rising edge
//  reset         in  1      asynchronous, active-high
//  PCWre         in  1      1 = PC advances this cycle; 0 = hold
//  pc_src        in  2      00 seq, 01 branch, 10 jump, 11 register/return
//  branch_off    in  WIDTH  sign-extended word offset
//  jump_addr     in  WIDTH  absolute jump target
//  rs_value      in  WIDTH  register-file target for pc_src=11
//  ras_push      in  1      call: push PC+4 when the PC advances
//  ras_pop       in  1      return: with pc_src=11, take target from RAS
//  halt          in  1      enter HALT
//  PC            out WIDTH  current PC
//  pc_plus4      out WIDTH  PC+4 (link value)
//  pc_valid      out 1      0 in BOOT/HALT, 1 in RUN
//  halted        out 1      1 in HALT
//  ras_empty     out 1      RAS count == 0
//  ras_full      out 1      RAS count == RAS_DEPTH
//  ras_ovf       out 1      sticky: push while full occurred
//  trap          out 1      one-cycle pulse on misaligned redirect (0 if PC_TRAP_EN undefined)
// BEHAVIOUR
//  Reset (async): PC=RESET_VECTOR, state=BOOT, RAS count=0, ras_ovf=0, trap=0, pc_valid=0, halted=0.
//  FSM: BOOT -> RUN next edge unconditionally (PC held); RUN -> HALT when halt=1 at edge; HALT -> exits only by reset.
//  RUN, PCWre=1: PC <= next; PCWre=0: PC, RAS and flags hold. halt takes priority over PCWre.
//  next: 00 PC+4; 01 PC+4+(branch_off<<2); 10 jump_addr; 11 (ras_pop & !ras_empty) ? RAS top : rs_value.
//  All adds modulo 2^WIDTH (wrap, no flag). pc_plus4 combinational from PC.
//  RAS updates only when PC advances. push: store PC+4 at top, count++.
//  Push while full: overwrite oldest (circular), count stays RAS_DEPTH, ras_ovf<=1.
//  Pop (pc_src=11 & ras_pop) while empty: uses rs_value, count stays 0, no error.
//  ras_pop ignored unless pc_src=11.
//  Push+pop same cycle: target = old top; top replaced by PC+4; count unchanged.
//  Latency: next PC visible on PC one cycle after edge with PCWre=1; no bypass.
//  Reset mid-operation: everything returns to reset values immediately; RAS contents are don't-care.
// CONFIGURATION
//  PC_TRAP_EN defined: target[1:0]!=0 -> PC<=TRAP_VECTOR, trap=1 one cycle, RAS not modified that cycle.
//  PC_TRAP_EN undefined: target[1:0] forced to 2'b00, trap tied 0.
// STRUCTURE
//  Package pc_pkg: pc_src encodings (PC_SEQ/PC_BR/PC_JMP/PC_REG), FSM state encodings (BOOT/RUN/HALT).
//  One sub-module pc_ras: circular stack, ptr + count, outputs top/empty/full/ovf.
//  pc_unit: FSM, next-PC mux/adders, PC register, trap logic.
// TESTING
//  Reset, RESET_VECTOR=0: PC=0, pc_valid=0; one edge -> pc_valid=1; 3 edges pc_src=00 -> PC=0x0C.
//  PC=0x10, pc_src=01, branch_off=-2 -> PC=0x0C; PCWre=0 with pc_src=10 -> PC stays 0x0C.
//  Push at PC=0x20,0x40 (jump 0x40 then 0x100); pc_src=11 ras_pop -> PC=0x44, then 0x24, then rs_value (empty).
//  RAS_DEPTH=4: 5 pushes -> ras_full=1, ras_ovf=1; 4 pops return the 4 newest links in LIFO order.
//  PC_TRAP_EN: jump_addr=0x102 -> PC=TRAP_VECTOR, trap pulse 1 cycle; undefined -> PC=0x100, trap=0.
//  halt=1 with PCWre=1 -> PC frozen, halted=1; async reset mid-cycle -> PC=RESET_VECTOR, BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: next-PC source select and FSM states.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10,
        PC_REG = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry and sets a sticky overflow flag.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] link_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             do_pop;

    // ptr_q is the next free slot, so the top of stack sits one below it
    assign top_idx = ptr_q - PW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign ovf_o   = ovf_q;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_i && !do_pop) begin
            ptr_d = ptr_q + PW'(1);
            if (full_o) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !push_i) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // A simultaneous push and pop replaces the current top in place
    always_ff @(posedge clk_i) begin
        if (push_i && do_pop)
            mem_q[top_idx] <= link_i;
        else if (push_i)
            mem_q[ptr_q] <= link_i;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run/halt FSM, next-PC selection, stall and return-address stack.
// Optional macro PC_TRAP_EN redirects misaligned targets to TRAP_VECTOR with a one-cycle trap pulse.
//
// state | meaning
// BOOT  | out of reset, PC held one cycle, pc_valid low
// RUN   | PC advances whenever PCWre_i is high
// HALT  | PC frozen until reset
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080)
) (
    input  logic             click_i,
    input  logic             reset_i,
    input  logic             PCWre_i,
    input  logic [1:0]       pc_src_i,
    input  logic [WIDTH-1:0] branch_off_i,
    input  logic [WIDTH-1:0] jump_addr_i,
    input  logic [WIDTH-1:0] rs_value_i,
    input  logic             ras_push_i,
    input  logic             ras_pop_i,
    input  logic             halt_i,
    output logic [WIDTH-1:0] PC_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             pc_valid_o,
    output logic             halted_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_ovf_o,
    output logic             trap_o
);
    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] next_raw, aligned, target, ras_top;
    logic             trap_q, trap_d;
    logic             advance, misalign, ras_adv, is_reg, ras_push, ras_pop;

    always_ff @(posedge click_i or posedge reset_i) begin
        if (reset_i) state_q <= BOOT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_valid_o = 1'b0;
        halted_o   = 1'b0;
        case (state_q)
            RUN:     pc_valid_o = 1'b1;
            HALT:    halted_o   = 1'b1;
            default: ;
        endcase
    end

    assign pc_plus4_o = pc_q + WIDTH'(4);
    assign is_reg     = (pc_src_i == PC_REG);
    assign advance    = (state_q == RUN) & PCWre_i & ~halt_i;

    always_comb begin
        next_raw = pc_plus4_o;
        case (pc_src_i)
            PC_SEQ:  next_raw = pc_plus4_o;
            PC_BR:   next_raw = pc_plus4_o + (branch_off_i << 2);
            PC_JMP:  next_raw = jump_addr_i;
            PC_REG:  next_raw = (ras_pop_i && !ras_empty_o) ? ras_top : rs_value_i;
            default: next_raw = pc_plus4_o;
        endcase
    end

`ifdef PC_TRAP_EN
    assign misalign = |next_raw[1:0];
    assign aligned  = next_raw;
`else
    assign misalign = 1'b0;
    assign aligned  = next_raw & ~WIDTH'(3);
`endif

    assign target  = misalign ? TRAP_VECTOR : aligned;
    assign pc_d    = advance ? target : pc_q;
    assign trap_d  = advance & misalign;

    // A trapped redirect leaves the stack untouched so the faulting call/return has no side effect
    assign ras_adv  = advance & ~misalign;
    assign ras_push = ras_adv & ras_push_i;
    assign ras_pop  = ras_adv & is_reg & ras_pop_i;

    always_ff @(posedge click_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q   <= RESET_VECTOR;
            trap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            trap_q <= trap_d;
        end
    end

    assign PC_o   = pc_q;
    assign trap_o = trap_q;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (click_i),
        .rst_i   (reset_i),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .link_i  (pc_plus4_o),
        .top_o   (ras_top),
        .empty_o (ras_empty_o),
        .full_o  (ras_full_o),
        .ovf_o   (ras_ovf_o)
    );

endmodule
